// File: rtl/rr_req_grant_pkg.sv
// Shared types, defaults and helpers for the round-robin request/grant controller.
package rr_req_grant_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StWait  = 2'd1,
      StGrant = 2'd2
   } state_e;

   localparam int unsigned DefNReq     = 4;
   localparam int unsigned DefWaitCyc  = 2;
   localparam int unsigned DefGrantCyc = 1;

   // Index of the set bit of a one-hot vector (highest set bit if not one-hot).
   function automatic int unsigned onehot2bin(input logic [31:0] oh);
      int unsigned idx;
      logic [31:0] sh;
      idx = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         sh = oh >> i;
         if (sh[0]) idx = i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first request at or above the priority pointer, wrapping.
module rr_pick import rr_req_grant_pkg::*; #(
   parameter int unsigned N_REQ = DefNReq,
   localparam int unsigned IdW  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] prio,
   output logic             found,
   output logic [N_REQ-1:0] win_oh,
   output logic [IdW-1:0]   win_idx
);

   int unsigned      base;
   int unsigned      pos;
   logic [N_REQ-1:0] req_rot;
   logic [N_REQ-1:0] rot_sh;

   always_comb begin
      base    = onehot2bin(32'(prio));
      // Rotate so the priority position lands on bit 0; doubling handles the wrap.
      req_rot = N_REQ'({req, req} >> base);
      found   = 1'b0;
      pos     = 0;
      rot_sh  = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         rot_sh = req_rot >> i;
         if (!found && rot_sh[0]) begin
            found = 1'b1;
            pos   = base + i;
         end
      end
      if (pos >= N_REQ) pos = pos - N_REQ;
      win_idx = IdW'(pos);
      win_oh  = found ? (N_REQ'(1) << win_idx) : '0;
   end

endmodule

// File: rtl/rr_req_grant.sv
// Round-robin request/grant controller: accept one request, wait WAIT_CYC, grant for
// GRANT_CYC cycles, then return to idle and advance the priority pointer past the winner.
module rr_req_grant import rr_req_grant_pkg::*; #(
   parameter int unsigned N_REQ     = DefNReq,
   parameter int unsigned WAIT_CYC  = DefWaitCyc,
   parameter int unsigned GRANT_CYC = DefGrantCyc,
   localparam int unsigned IdW      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [N_REQ-1:0] req,
   output logic             idle,
   output logic             busy,
   output logic [N_REQ-1:0] grant,
   output logic [IdW-1:0]   grant_id,
   output logic [N_REQ-1:0] prio
);

   localparam int unsigned MaxCyc = (WAIT_CYC > GRANT_CYC) ? WAIT_CYC : GRANT_CYC;
   localparam int unsigned CntW   = $clog2(MaxCyc + 1);

   state_e           state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [IdW-1:0]   win_q, win_d;
   logic [N_REQ-1:0] prio_q, prio_d;
   logic [N_REQ-1:0] grant_q, grant_d;

   logic             pick_found;
   logic [N_REQ-1:0] pick_oh;
   logic [IdW-1:0]   pick_idx;

   rr_pick #(
      .N_REQ (N_REQ)
   ) u_pick (
      .req     (req),
      .prio    (prio_q),
      .found   (pick_found),
      .win_oh  (pick_oh),
      .win_idx (pick_idx)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      win_d   = win_q;
      prio_d  = prio_q;
      grant_d = grant_q;
      unique case (state_q)
         StIdle: begin
            if (pick_found) begin
               win_d = pick_idx;
               if (WAIT_CYC == 0) begin
                  state_d = StGrant;
                  cnt_d   = CntW'(GRANT_CYC);
                  grant_d = pick_oh;
               end else begin
                  state_d = StWait;
                  cnt_d   = CntW'(WAIT_CYC);
               end
            end
         end
         StWait: begin
            if (cnt_q <= CntW'(1)) begin
               state_d = StGrant;
               cnt_d   = CntW'(GRANT_CYC);
               grant_d = N_REQ'(1) << win_q;
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         StGrant: begin
            if (cnt_q <= CntW'(1)) begin
               state_d = StIdle;
               grant_d = '0;
               // Next search starts just above the winner.
               prio_d  = (win_q == IdW'(N_REQ - 1)) ? N_REQ'(1)
                                                    : (N_REQ'(1) << (win_q + IdW'(1)));
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         default: begin
            state_d = StIdle;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         win_q   <= '0;
         prio_q  <= N_REQ'(1);
         grant_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         win_q   <= win_d;
         prio_q  <= prio_d;
         grant_q <= grant_d;
      end
   end

   assign idle     = (state_q == StIdle);
   assign busy     = !idle;
   assign grant    = grant_q;
   assign grant_id = win_q;
   assign prio     = prio_q;

endmodule

// File: tb/tb_rr_req_grant.sv
// Bench for rr_req_grant: directed steps plus random requests/resets against a
// transaction-level model that tracks acceptance time, winner and pointer.
module tb_rr_req_grant;

   localparam int WD = 2;
   localparam int GD = 1;

   logic       clk;
   logic       rst_n;
   logic [3:0] req_a;
   logic       req_1;

   logic       idle_a, busy_a;
   logic [3:0] grant_a, prio_a;
   logic [1:0] gid_a;

   logic       idle_w0, busy_w0, grant_w0, gid_w0, prio_w0;
   logic       idle_d1, busy_d1, grant_d1, gid_d1, prio_d1;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   // Model state: outstanding transaction, accepted at edge m_acc.
   bit m_active = 1'b0;
   int m_acc    = 0;
   int m_win    = 0;
   int m_gid    = 0;
   int m_prio   = 0;

   rr_req_grant u_dut (
      .clk      (clk),
      .reset_n  (rst_n),
      .req      (req_a),
      .idle     (idle_a),
      .busy     (busy_a),
      .grant    (grant_a),
      .grant_id (gid_a),
      .prio     (prio_a)
   );

   rr_req_grant #(
      .N_REQ     (1),
      .WAIT_CYC  (0),
      .GRANT_CYC (3)
   ) u_w0 (
      .clk      (clk),
      .reset_n  (rst_n),
      .req      (req_1),
      .idle     (idle_w0),
      .busy     (busy_w0),
      .grant    (grant_w0),
      .grant_id (gid_w0),
      .prio     (prio_w0)
   );

   rr_req_grant #(
      .N_REQ (1)
   ) u_d1 (
      .clk      (clk),
      .reset_n  (rst_n),
      .req      (req_1),
      .idle     (idle_d1),
      .busy     (busy_d1),
      .grant    (grant_d1),
      .grant_id (gid_d1),
      .prio     (prio_d1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int scan(input logic [3:0] r, input int p);
      logic [3:0] sh;
      for (int i = 0; i < 4; i++) begin
         sh = r >> ((p + i) % 4);
         if (sh[0]) return (p + i) % 4;
      end
      return -1;
   endfunction

   task automatic model_step();
      if (!rst_n) begin
         m_active = 1'b0;
         m_prio   = 0;
         m_gid    = 0;
      end else if (m_active) begin
         if (cyc - m_acc == WD + GD) begin
            m_active = 1'b0;
            m_prio   = (m_win + 1) % 4;
         end
      end else if (req_a != 4'd0) begin
         m_active = 1'b1;
         m_acc    = cyc;
         m_win    = scan(req_a, m_prio);
         m_gid    = m_win;
      end
   endtask

   task automatic check_dut();
      logic [31:0] exp_grant;
      exp_grant = (m_active && (cyc - m_acc) >= WD) ? (32'd1 << m_win) : 32'd0;
      chk("idle", 32'(idle_a), 32'(!m_active));
      chk("busy", 32'(busy_a), 32'(m_active));
      chk("grant", 32'(grant_a), exp_grant);
      chk("grant_id", 32'(gid_a), 32'(m_gid));
      chk("prio", 32'(prio_a), 32'd1 << m_prio);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      model_step();
      check_dut();
   endtask

   initial begin
      rst_n = 1'b0;
      req_a = 4'd0;
      req_1 = 1'b0;
      tick();
      tick();
      chk("rst_idle", 32'(idle_a), 32'd1);
      chk("rst_busy", 32'(busy_a), 32'd0);
      chk("rst_grant", 32'(grant_a), 32'd0);
      chk("rst_prio", 32'(prio_a), 32'd1);
      chk("rst_id", 32'(gid_a), 32'd0);

      rst_n = 1'b1;
      repeat (20) tick();
      chk("quiet_prio", 32'(prio_a), 32'd1);
      chk("quiet_idle", 32'(idle_a), 32'd1);

      // Single one-cycle request.
      req_a = 4'b0001;
      tick();
      req_a = 4'd0;
      chk("single_busy", 32'(busy_a), 32'd1);
      tick();
      chk("single_early", 32'(grant_a), 32'd0);
      tick();
      chk("single_grant", 32'(grant_a), 32'd1);
      tick();
      chk("single_idle", 32'(idle_a), 32'd1);
      chk("single_prio", 32'(prio_a), 32'd2);

      // All requesting from a fresh pointer: rotate 0,1,2,3,0 every 4 cycles.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      req_a = 4'hF;
      tick();
      for (int k = 0; k < 5; k++) begin
         tick();
         tick();
         chk("rr_grant", 32'(grant_a), 32'(1 << (k % 4)));
         chk("rr_id", 32'(gid_a), 32'(k % 4));
         tick();
         chk("rr_gap_idle", 32'(idle_a), 32'd1);
         tick();
      end
      req_a = 4'd0;
      repeat (3) tick();
      chk("rr_end_prio", 32'(prio_a), 32'd4);

      // Wrap past the top; late requests during WAIT are ignored.
      req_a = 4'b0011;
      tick();
      req_a = 4'b1000;
      tick();
      tick();
      chk("wrap_grant", 32'(grant_a), 32'd1);
      req_a = 4'd0;
      tick();
      chk("wrap_prio", 32'(prio_a), 32'd2);

      // Reset during WAIT drops the transaction without advancing the pointer.
      req_a = 4'b0100;
      tick();
      req_a = 4'd0;
      tick();
      rst_n = 1'b0;
      tick();
      chk("abort_idle", 32'(idle_a), 32'd1);
      chk("abort_prio", 32'(prio_a), 32'd1);
      rst_n = 1'b1;
      repeat (4) begin
         tick();
         chk("abort_nogrant", 32'(grant_a), 32'd0);
      end

      // Single-requester instances.
      req_1 = 1'b1;
      for (int j = 0; j < 5; j++) begin
         tick();
         req_1 = 1'b0;
         chk("w0_grant", 32'(grant_w0), (32'h07 >> j) & 32'd1);
         chk("w0_idle", 32'(idle_w0), (32'h18 >> j) & 32'd1);
         chk("w0_busy", 32'(busy_w0), (32'h07 >> j) & 32'd1);
         chk("d1_grant", 32'(grant_d1), (32'h04 >> j) & 32'd1);
         chk("d1_idle", 32'(idle_d1), (32'h18 >> j) & 32'd1);
         chk("d1_busy", 32'(busy_d1), (32'h07 >> j) & 32'd1);
      end
      chk("w0_id", 32'(gid_w0), 32'd0);
      chk("w0_prio", 32'(prio_w0), 32'd1);
      chk("d1_id", 32'(gid_d1), 32'd0);
      chk("d1_prio", 32'(prio_d1), 32'd1);

      // Random requests with occasional resets.
      for (int i = 0; i < 400; i++) begin
         req_a = 4'($urandom_range(0, 15));
         rst_n = ($urandom_range(0, 49) != 0);
         tick();
      end
      rst_n = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/rr_req_grant.md
# rr_req_grant

Parametrised round-robin request/grant controller: N_REQ requesters compete for one shared resource; the block accepts one request from idle, waits a fixed programmable latency, asserts a one-hot grant for a programmable number of cycles, then returns to idle. A rotating one-hot priority pointer gives fair service. With N_REQ=1, WAIT_CYC=2, GRANT_CYC=1 it matches the existing single-channel request/grant handshake cycle for cycle.

## Interface
- N_REQ, 4: number of requesters, ≥1.
- WAIT_CYC, 2: cycles spent in WAIT between acceptance and grant, ≥0.
- GRANT_CYC, 1: cycles grant stays asserted, ≥1.
- clk  in  1  clock, all state on rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- req  in  N_REQ  per-requester request level; sampled only in IDLE.
- idle  out  1  high in IDLE.
- busy  out  1  high in WAIT or GRANT (= !idle).
- grant  out  N_REQ  one-hot grant to the winner during GRANT, else 0.
- grant_id  out  max(1,$clog2(N_REQ))  binary index of current or last winner.
- prio  out  N_REQ  one-hot priority pointer (debug/visibility).

## Operation
- States: IDLE, WAIT, GRANT.
- IDLE: if |req, pick the winner, latch its index, load counter; go to WAIT (WAIT_CYC>0) or straight to GRANT (WAIT_CYC=0). If req==0, stay.
- Winner: first set bit of req scanning upward from the position of prio, wrapping from N_REQ-1 to 0.
- WAIT: counter counts WAIT_CYC cycles, then GRANT; req ignored (deassertion does not cancel the grant, new requests not latched).
- GRANT: grant = one-hot(winner) for GRANT_CYC cycles, then IDLE unconditionally. At GRANT exit prio ← rotate-left(one-hot(winner)), i.e. winner+1 mod N_REQ.
- At least one IDLE cycle between grants; back-to-back grants are impossible.
- Counter width $clog2(max(WAIT_CYC,GRANT_CYC)+1); counts down to 1 then transitions; no wrap.
- Invariants: grant one-hot or zero; grant≠0 only in GRANT; prio always one-hot; idle and busy mutually exclusive.

## Timing
- Reset (any state, incl. mid-WAIT/GRANT): next edge → IDLE, grant=0, grant_id=0, idle=1, busy=0, prio=1 (bit 0); in-flight grant dropped, pointer not advanced.
- req sampled in IDLE at edge t → busy from t+1; grant asserted edges t+1+WAIT_CYC through t+WAIT_CYC+GRANT_CYC; idle again at t+1+WAIT_CYC+GRANT_CYC.
- Service period under continuous requests: WAIT_CYC+GRANT_CYC+1 cycles.
- grant_id valid from the cycle after acceptance, holds until next acceptance.
- All outputs registered or decoded from registered state only; no combinational path req → any output.

## Structure
- Shared package rr_req_grant_pkg: state typedef (IDLE, WAIT, GRANT encodings), onehot2bin function, default parameter constants.
- One sub-module rr_pick: combinational round-robin picker (req, prio → one-hot winner, binary index), parametrised on N_REQ, reusable by other arbiters.
- Top holds FSM, counter, winner register, prio register.

## Test plan
- Defaults, reset held 2 cycles → idle=1, busy=0, grant=0000, prio=0001; 20 cycles with req=0 → no change.
- req=0001 one cycle at IDLE edge t → grant=0001 at t+3 only, idle=1 at t+4, prio=0010.
- req=1111 held → grants 0001,0010,0100,1000,0001 at 4-cycle period, grant_id 0,1,2,3,0.
- prio=0100 (after winner 1), req=0011 → winner 0001 (wrap); req changed to 1000 during WAIT → grant still 0001.
- req=0100 at t, reset_n low at t+2 (in WAIT) → no grant ever issued, prio=0001, idle=1 at t+3.
- Instance N_REQ=1, WAIT_CYC=0, GRANT_CYC=3: req at t → grant=1 at t+1..t+3, idle at t+4; instance N_REQ=1 defaults → grant exactly 3 cycles after req.
